// File: rtl/polar_decoder_pkg.sv
// Shared definitions for the polar decoder: controller state encoding and
// the code-length helper used to size the stage counter.
package polar_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } polar_state_e;

    // log2 of a power-of-two codeword length (N >= 2).
    function automatic int log2n(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < n) r = k + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/polar_decoder_if.sv
// Frame handshake bundle for the polar decoder.
//   in_valid/in_ready   : codeword handshake (in_x codeword, in_frozen mask)
//   out_valid/out_ready : decoded-frame handshake (out_u, out_frozen_err)
//   frame_cnt           : frames delivered since reset
// slave  : the decoder side
// master : the producer/consumer side
interface polar_decoder_if #(parameter int N = 8);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_x;
    logic [N-1:0]  in_frozen;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_u;
    logic          out_frozen_err;
    logic [15:0]   frame_cnt;

    modport slave (
        input  in_valid, in_x, in_frozen, out_ready,
        output in_ready, out_valid, out_u, out_frozen_err, frame_cnt
    );

    modport master (
        output in_valid, in_x, in_frozen, out_ready,
        input  in_ready, out_valid, out_u, out_frozen_err, frame_cnt
    );
endinterface

// File: rtl/polar_decoder_stage.sv
// One butterfly stage of the polar decoder, purely combinational.
// For stage s (block size M = 2^s) every contiguous M-bit block of w_in is
// mapped as out[2i] = w[i] ^ w[i+M/2], out[2i+1] = w[i+M/2].
// Ports:
//   stage : stage index 1..LOG2N; any other value passes w_in through
//   w_in  : working vector before the stage
//   w_out : working vector after the stage
module polar_decoder_stage
    import polar_decoder_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic [SW-1:0] stage,
    input  logic [N-1:0]  w_in,
    output logic [N-1:0]  w_out
);

    localparam int LOG2N = log2n(N);

    // res[t] holds the result of stage t; the index picks one.
    logic [LOG2N:1][N-1:0] res;

    for (genvar t = 1; t <= LOG2N; t++) begin : g_stage
        localparam int M = 1 << t;
        for (genvar blk = 0; blk < N / M; blk++) begin : g_blk
            for (genvar i = 0; i < M / 2; i++) begin : g_pair
                assign res[t][blk*M + 2*i]     = w_in[blk*M + i] ^ w_in[blk*M + i + M/2];
                assign res[t][blk*M + 2*i + 1] = w_in[blk*M + i + M/2];
            end
        end
    end

    always_comb begin
        w_out = w_in;
        for (int t = 1; t <= LOG2N; t++) begin
            if (stage == SW'(t)) w_out = res[t];
        end
    end

endmodule

// File: rtl/polar_decoder.sv
// Hard-decision polar decoder. Loads a codeword into a working register and
// applies one butterfly stage per cycle (smallest blocks first) until the
// register holds the message u with E_N(u) = x.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : polar_decoder_if.slave (frame handshake, result, frame counter)
// Parameter N: codeword length, power of two, at least 2.
//
// state | meaning
// IDLE  | waiting for a codeword, in_ready = 1
// RUN   | applying stage s_q to the working register, one stage per cycle
// DONE  | decoded frame presented, out_valid = 1, held until out_ready
module polar_decoder
    import polar_decoder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    polar_decoder_if.slave  bus
);

    localparam int LOG2N = log2n(N);
    // LOG2N bits always suffice to hold the value LOG2N itself.
    localparam int SW    = LOG2N;

    polar_state_e   state_q, state_d;
    logic [N-1:0]   w_q;
    logic [N-1:0]   mask_q;
    logic [N-1:0]   stage_w;
    logic [SW-1:0]  s_q;
    logic [15:0]    cnt_q;
    logic           load;
    logic           step;
    logic           deliver;

    polar_decoder_stage #(.N(N), .SW(SW)) u_stage (
        .stage (s_q),
        .w_in  (w_q),
        .w_out (stage_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            w_q     <= '0;
            mask_q  <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                w_q    <= bus.in_x;
                mask_q <= bus.in_frozen;
                s_q    <= SW'(1);
            end
            if (step) begin
                w_q <= stage_w;
                s_q <= s_q + SW'(1);
            end
            if (deliver) cnt_q <= cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d       = state_q;
        load          = 1'b0;
        step          = 1'b0;
        deliver       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (s_q == SW'(LOG2N)) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                // Return to IDLE only; the next frame is taken a cycle later.
                if (bus.out_ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_u          = w_q;
    assign bus.out_frozen_err = |(w_q & mask_q);
    assign bus.frame_cnt      = cnt_q;

endmodule

// File: tb/tb_polar_decoder.sv
module tb_polar_decoder;

    logic clk;
    logic rst_n;
    logic out_rdy;

    polar_decoder_if #(.N(2)) if2 ();
    polar_decoder_if #(.N(4)) if4 ();
    polar_decoder_if #(.N(8)) if8 ();

    assign if2.out_ready = out_rdy;
    assign if4.out_ready = out_rdy;
    assign if8.out_ready = out_rdy;

    polar_decoder #(.N(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    polar_decoder #(.N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    polar_decoder #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [15:0] exp_cnt [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference encoder, written from the recursive definition.
    function automatic logic [1:0] enc2(input logic [1:0] u);
        return {u[1], u[0] ^ u[1]};
    endfunction

    function automatic logic [3:0] enc4(input logic [3:0] u);
        logic [1:0] a, b;
        a = {u[2] ^ u[3], u[0] ^ u[1]};
        b = {u[3], u[1]};
        return {enc2(b), enc2(a)};
    endfunction

    function automatic logic [7:0] enc8(input logic [7:0] u);
        logic [3:0] a, b;
        a = {u[6] ^ u[7], u[4] ^ u[5], u[2] ^ u[3], u[0] ^ u[1]};
        b = {u[7], u[5], u[3], u[1]};
        return {enc4(b), enc4(a)};
    endfunction

    // sel: 0 -> N=2, 1 -> N=4, 2 -> N=8
    task automatic drive(input int sel, input logic v, input logic [7:0] x, input logic [7:0] m);
        case (sel)
            0: begin if2.in_valid = v; if2.in_x = x[1:0]; if2.in_frozen = m[1:0]; end
            1: begin if4.in_valid = v; if4.in_x = x[3:0]; if4.in_frozen = m[3:0]; end
            default: begin if8.in_valid = v; if8.in_x = x; if8.in_frozen = m; end
        endcase
    endtask

    function automatic logic dv(input int sel);
        case (sel)
            0: return if2.out_valid;
            1: return if4.out_valid;
            default: return if8.out_valid;
        endcase
    endfunction

    function automatic logic dr(input int sel);
        case (sel)
            0: return if2.in_ready;
            1: return if4.in_ready;
            default: return if8.in_ready;
        endcase
    endfunction

    function automatic logic [7:0] du(input int sel);
        case (sel)
            0: return {6'd0, if2.out_u};
            1: return {4'd0, if4.out_u};
            default: return if8.out_u;
        endcase
    endfunction

    function automatic logic de(input int sel);
        case (sel)
            0: return if2.out_frozen_err;
            1: return if4.out_frozen_err;
            default: return if8.out_frozen_err;
        endcase
    endfunction

    function automatic logic [15:0] dc(input int sel);
        case (sel)
            0: return if2.frame_cnt;
            1: return if4.frame_cnt;
            default: return if8.frame_cnt;
        endcase
    endfunction

    // One frame with out_ready held at 1; called in IDLE, #1 after an edge.
    task automatic run_frame(input int sel, input logic [7:0] x, input logic [7:0] m,
                             input logic [7:0] exp_u, input logic exp_err,
                             input int exp_lat, input string tag, output int acc_cyc);
        int lat;
        check({tag, "_rdy"}, dr(sel), 1);
        drive(sel, 1'b1, x, m);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        drive(sel, 1'b0, 8'd0, 8'd0);
        lat = 0;
        while (!dv(sel) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_u"}, du(sel), exp_u);
        check({tag, "_err"}, de(sel), exp_err);
        @(posedge clk); #1;
        exp_cnt[sel] = exp_cnt[sel] + 16'd1;
        check({tag, "_cnt"}, dc(sel), exp_cnt[sel]);
        check({tag, "_vld0"}, dv(sel), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, lat;
        logic [7:0] u, m;

        exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cnt[2] = 0;
        out_rdy = 1'b1;
        rst_n   = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'd0, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("rst%0d_rdy", s), dr(s), 1);
            check($sformatf("rst%0d_vld", s), dv(s), 0);
            check($sformatf("rst%0d_u", s), du(s), 0);
            check($sformatf("rst%0d_err", s), de(s), 0);
            check($sformatf("rst%0d_cnt", s), dc(s), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset in the second RUN cycle discards the frame.
        drive(2, 1'b1, enc8(8'hA5), 8'h00);
        @(posedge clk); #1;
        drive(2, 1'b0, 8'd0, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", dv(2), 0);
        check("mid_rst_cnt", dc(2), 0);
        check("mid_rst_rdy", dr(2), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_vld", dv(2), 0);
        check("post_rst_cnt", dc(2), 0);
        run_frame(2, 8'hFF, 8'h00, 8'h80, 1'b0, 3, "after_rst", acc);

        // N=2 and N=4 hand vectors.
        run_frame(0, 8'h01, 8'h00, 8'h01, 1'b0, 1, "n2_a", acc);
        run_frame(0, 8'h03, 8'h01, 8'h02, 1'b0, 1, "n2_b", acc);
        run_frame(1, 8'h0F, 8'h07, 8'h08, 1'b0, 2, "n4_a", acc);
        run_frame(1, 8'h01, 8'h07, 8'h01, 1'b1, 2, "n4_b", acc);

        // N=8 hand vectors.
        run_frame(2, 8'h01, 8'h00, 8'h01, 1'b0, 3, "n8_a", acc);
        run_frame(2, 8'h0F, 8'h40, 8'h40, 1'b1, 3, "n8_b", acc);
        run_frame(2, 8'h00, 8'hFF, 8'h00, 1'b0, 3, "n8_c", acc);

        // Stall in DONE with a competing in_valid.
        out_rdy = 1'b0;
        drive(2, 1'b1, 8'hFF, 8'h7F);
        @(posedge clk); #1;
        drive(2, 1'b1, 8'h01, 8'h00);
        lat = 0;
        while (!dv(2) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("stall_lat", lat, 3);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_u", k), du(2), 8'h80);
            check($sformatf("stall%0d_err", k), de(2), 0);
            check($sformatf("stall%0d_rdy", k), dr(2), 0);
            check($sformatf("stall%0d_vld", k), dv(2), 1);
            check($sformatf("stall%0d_cnt", k), dc(2), exp_cnt[2]);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        drive(2, 1'b0, 8'd0, 8'd0);
        exp_cnt[2] = exp_cnt[2] + 16'd1;
        check("stall_rel_cnt", dc(2), exp_cnt[2]);
        check("stall_rel_rdy", dr(2), 1);
        check("stall_rel_vld", dv(2), 0);
        @(posedge clk); #1;
        check("stall_noacc_rdy", dr(2), 1);
        check("stall_noacc_cnt", dc(2), exp_cnt[2]);

        // 1000 pseudo-random frames through the N=8 block, back to back.
        rst_n = 1'b0;
        #1;
        exp_cnt[0] = 0; exp_cnt[1] = 0; exp_cnt[2] = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        prev = 0;
        for (int f = 0; f < 1000; f++) begin
            u = 8'($urandom);
            m = 8'($urandom);
            run_frame(2, enc8(u), m, u, |(u & m), 3, $sformatf("rnd%0d", f), acc);
            if (f > 0) check($sformatf("rnd%0d_period", f), acc - prev, 5);
            prev = acc;
        end
        check("rnd_final_cnt", dc(2), 16'h03E8);

        // Counter wrap: preload 65535 deliveries on the N=2 block.
        force u_dut2.cnt_q = 16'hFFFF;
        #1;
        release u_dut2.cnt_q;
        #1;
        exp_cnt[0] = 16'hFFFF;
        check("wrap_pre_cnt", dc(0), 16'hFFFF);
        run_frame(0, 8'h02, 8'h00, 8'h03, 1'b0, 1, "wrap", acc);
        check("wrap_zero", dc(0), 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
